match_sm: RTL and testbench
===========================

# match_sm

Parametrised match-state controller for Tank Wars, successor to the fixed two-player `game_sm`. It tracks lives for up to four tanks and applies post-hit invulnerability windows. It detects the end of the match and reports the winner or a draw, and handles restart from the USB keycode. It sits beside the `ball`/`bullet` instances, takes per-player hit flags from them, and drives heart, blink and game-over information to `color_mapper`.

## Interface
Parameters:
- `N_PLAYERS`, default 2: number of tanks, legal range 2..4.
- `LIVES`, default 3: starting and maximum lives per player, legal range 1..7.
- `INVULN_FRAMES`, default 30: frames of hit immunity after a hit, legal range 0..255.
- `PICKUP_PERIOD`, default 600: frames between heart spawns, legal range 1..4095.
- `RESTART_KEY`, default 8'h15: USB HID usage code of the restart key ('R').

Ports:
- `Clk`, input, 1 bit: system clock (MAX10_CLK1_50). There is one clock domain.
- `Reset_n`, input, 1 bit: asynchronous, active-low reset.
- `frame_tick`, input, 1 bit: one-`Clk` pulse per video frame, derived from the VS edge.
- `shot_hit`, input, N_PLAYERS bits: bit p high means tank p is hit by an enemy bullet this frame.
- `pickup_touch`, input, N_PLAYERS bits: bit p high means tank p overlaps the heart sprite.
- `keycode`, input, 32 bits: four packed USB keycode bytes.
- `hearts`, output, 3*N_PLAYERS bits: lives of player p, located at bits [3p+2:3p].
- `alive`, output, N_PLAYERS bits: bit p is high while lives of player p are above 0.
- `invuln`, output, N_PLAYERS bits: bit p is high while player p's immunity counter is nonzero. `color_mapper` uses it for blink.
- `game_over`, output, 1 bit: high in state OVER.
- `draw`, output, 1 bit: high in OVER when no player survived.
- `winner`, output, 2 bits: index of the surviving player. Valid only when `game_over`=1 and `draw`=0.
- `heart_showup`, output, 1 bit: high while a heart pickup is on screen.

## Operation
- The state machine has two states, PLAY and OVER. Reset puts it in PLAY.
- All game state changes only on cycles where `frame_tick`=1. `shot_hit`, `pickup_touch` and `keycode` are ignored on all other cycles.
- Processing in PLAY on each tick, for each player p in parallel:
  - First, if `invuln[p]` is nonzero, decrement its counter by 1.
  - Otherwise, if `shot_hit[p]`=1 and `hearts[p]`>0, decrement `hearts[p]` by 1 and load the counter with INVULN_FRAMES.
  - The counter is checked before it is decremented: a counter of 1 still blocks a hit on this tick.
  - Hits on several players in the same tick are all applied.
- End of match: after the hit update, if the count of set `alive` bits is at most 1, go to OVER.
  - With exactly one survivor: `winner` = that player's index and `draw`=0.
  - With no survivors: `draw`=1 and `winner`=0.
- In OVER:
  - Hits and pickups are ignored, and invuln counters are cleared.
  - On a tick where any `keycode` byte equals RESTART_KEY: reload all hearts to LIVES, clear invuln, `draw` and `winner`, restart the pickup timer, and go to PLAY.
  - In PLAY, RESTART_KEY has no effect.
- Lives never underflow below 0 and never exceed LIVES.

## Timing
- All outputs are registered. Every update is visible on the `Clk` cycle after the `frame_tick` cycle, so latency is 1 cycle.
- Reset values: `hearts`=LIVES in every field, `alive`=all ones, `invuln`=0, `game_over`=0, `draw`=0, `winner`=0, `heart_showup`=0, frame counter=0.
- Assertion of `Reset_n` in any state returns all outputs to the reset values immediately. No pending tick is retained.
- If two players would both be reduced to 0 on the same tick, both die and the result is a draw.
- `frame_tick` held high for several cycles is a bench error. Each high cycle counts as a separate frame.

## Configuration
- Macro `TANKWARS_HEART_PICKUP_EN`.
- When defined:
  - A 12-bit frame counter runs in PLAY. When it reaches PICKUP_PERIOD-1 and `heart_showup`=0, it sets `heart_showup` and wraps to 0.
  - While `heart_showup`=1, on a tick, the lowest-index alive player with `pickup_touch` set gains 1 life, saturating at LIVES, and `heart_showup` clears.
  - Pickups are applied after hits within the same tick. A player killed on that tick cannot collect the pickup.
- When undefined: `heart_showup` is tied to 0, `pickup_touch` is unused, and no counter logic is built.

## Test plan
- Default parameters: apply a single-tick hit on player 0 → `hearts`[2:0]=2 and `invuln`[0]=1 one cycle after the tick. Hold `shot_hit`[0] for 30 more ticks → lives stay at 2. On the 31st tick → lives=1.
- Hits on P0 and P1 on the same tick with both at 1 life → `game_over`=1, `draw`=1, `winner`=0.
- N_PLAYERS=4, kill players 1, 2 and 3 → `game_over`=1, `draw`=0, `winner`=0. Then `keycode`=32'h0015_0000 on a tick → `hearts` all 3, `game_over`=0.
- `keycode` contains 8'h15 during PLAY → no state change. Assert `Reset_n` low mid-invulnerability → all outputs take reset values asynchronously.
- With TANKWARS_HEART_PICKUP_EN defined and PICKUP_PERIOD=4: `heart_showup` rises after the 4th tick. P0 at 2 lives and P1 at 3 lives both touch → P0 goes to 3 lives and `heart_showup` clears.
- With the macro undefined: run 1000 ticks with `pickup_touch` all ones → `heart_showup` stays 0 and no life changes.

Source files
------------

// File: rtl/match_sm.sv
// match_sm: Tank Wars lives, hit-immunity and end-of-match controller; TANKWARS_HEART_PICKUP_EN adds heart pickups.
// Latency: 1 cycle after frame_tick; no backpressure, every tick is consumed.
module match_sm #(
    parameter int          N_PLAYERS     = 2,
    parameter int          LIVES         = 3,
    parameter int          INVULN_FRAMES = 30,
    parameter int          PICKUP_PERIOD = 600,
    parameter logic [7:0]  RESTART_KEY   = 8'h15
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_tick,
    input  logic [N_PLAYERS-1:0]     shot_hit,
    input  logic [N_PLAYERS-1:0]     pickup_touch,
    input  logic [31:0]              keycode,
    output logic [3*N_PLAYERS-1:0]   hearts,
    output logic [N_PLAYERS-1:0]     alive,
    output logic [N_PLAYERS-1:0]     invuln,
    output logic                     game_over,
    output logic                     draw,
    output logic [1:0]               winner,
    output logic                     heart_showup
);

    typedef enum logic {PLAY, OVER} state_t;

    state_t     state_q, state_d;
    logic [2:0] lives_q [N_PLAYERS];
    logic [2:0] lives_d [N_PLAYERS];
    logic [7:0] cnt_q   [N_PLAYERS];
    logic [7:0] cnt_d   [N_PLAYERS];
    logic       draw_q, draw_d;
    logic [1:0] winner_q, winner_d;
    logic       restart;
    logic [2:0] n_alive;
    logic [1:0] last_alive;

`ifdef TANKWARS_HEART_PICKUP_EN
    logic [11:0] fcnt_q, fcnt_d;
    logic        showup_q, showup_d;
    logic        picked;
`endif

    assign restart = (keycode[7:0]   == RESTART_KEY) || (keycode[15:8]  == RESTART_KEY) ||
                     (keycode[23:16] == RESTART_KEY) || (keycode[31:24] == RESTART_KEY);

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        cnt_d      = cnt_q;
        draw_d     = draw_q;
        winner_d   = winner_q;
        n_alive    = 3'd0;
        last_alive = 2'd0;
`ifdef TANKWARS_HEART_PICKUP_EN
        fcnt_d     = fcnt_q;
        showup_d   = showup_q;
        picked     = 1'b0;
`endif
        if (frame_tick) begin
            case (state_q)
                PLAY: begin
                    // A running immunity counter consumes the tick, even if it is about to expire.
                    for (int p = 0; p < N_PLAYERS; p++) begin
                        if (cnt_q[p] != 8'd0) begin
                            cnt_d[p] = cnt_q[p] - 8'd1;
                        end else if (shot_hit[p] && (lives_q[p] != 3'd0)) begin
                            lives_d[p] = lives_q[p] - 3'd1;
                            cnt_d[p]   = 8'(INVULN_FRAMES);
                        end
                    end
`ifdef TANKWARS_HEART_PICKUP_EN
                    if (showup_q) begin
                        for (int p = 0; p < N_PLAYERS; p++) begin
                            if (!picked && pickup_touch[p] && (lives_d[p] != 3'd0)) begin
                                picked = 1'b1;
                                if (lives_d[p] < 3'(LIVES))
                                    lives_d[p] = lives_d[p] + 3'd1;
                            end
                        end
                        if (picked)
                            showup_d = 1'b0;
                    end else if (fcnt_q == 12'(PICKUP_PERIOD - 1)) begin
                        showup_d = 1'b1;
                        fcnt_d   = 12'd0;
                    end else begin
                        fcnt_d = fcnt_q + 12'd1;
                    end
`endif
                    for (int p = 0; p < N_PLAYERS; p++) begin
                        if (lives_d[p] != 3'd0) begin
                            n_alive    = n_alive + 3'd1;
                            last_alive = 2'(p);
                        end
                    end
                    if (n_alive <= 3'd1) begin
                        state_d  = OVER;
                        draw_d   = (n_alive == 3'd0);
                        winner_d = last_alive;
                        for (int p = 0; p < N_PLAYERS; p++)
                            cnt_d[p] = 8'd0;
`ifdef TANKWARS_HEART_PICKUP_EN
                        showup_d = 1'b0;
`endif
                    end
                end
                OVER: begin
                    for (int p = 0; p < N_PLAYERS; p++)
                        cnt_d[p] = 8'd0;
                    if (restart) begin
                        state_d  = PLAY;
                        draw_d   = 1'b0;
                        winner_d = 2'd0;
                        for (int p = 0; p < N_PLAYERS; p++)
                            lives_d[p] = 3'(LIVES);
`ifdef TANKWARS_HEART_PICKUP_EN
                        fcnt_d   = 12'd0;
                        showup_d = 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= PLAY;
            draw_q   <= 1'b0;
            winner_q <= 2'd0;
            for (int p = 0; p < N_PLAYERS; p++) begin
                lives_q[p] <= 3'(LIVES);
                cnt_q[p]   <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            draw_q   <= draw_d;
            winner_q <= winner_d;
            lives_q  <= lives_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef TANKWARS_HEART_PICKUP_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fcnt_q   <= 12'd0;
            showup_q <= 1'b0;
        end else begin
            fcnt_q   <= fcnt_d;
            showup_q <= showup_d;
        end
    end

    assign heart_showup = showup_q;
`else
    logic unused_touch;
    assign unused_touch = ^pickup_touch;
    assign heart_showup = 1'b0;
`endif

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_out
        assign hearts[3*p +: 3] = lives_q[p];
        assign alive[p]         = (lives_q[p] != 3'd0);
        assign invuln[p]        = (cnt_q[p] != 8'd0);
    end

    assign game_over = (state_q == OVER);
    assign draw      = draw_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_match_sm.sv
// Bench for match_sm: a 2-player default instance and a 4-player instance with a short pickup period.
module tb_match_sm;

    typedef struct {
        int          dut;
        int          pre;
        logic [3:0]  hit;
        logic [3:0]  touch;
        logic [31:0] key;
        logic [11:0] hearts;
        logic [3:0]  inv;
        logic        over;
        logic        drw;
        logic [1:0]  win;
        logic        show;
        bit          chk_show;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        tick_a, tick_b;
    logic [1:0]  shot_a, touch_a;
    logic [3:0]  shot_b, touch_b;
    logic [31:0] key_a, key_b;
    logic [5:0]  hearts_a;
    logic [11:0] hearts_b;
    logic [1:0]  alive_a, inv_a, win_a, win_b;
    logic [3:0]  alive_b, inv_b;
    logic        over_a, draw_a, show_a, over_b, draw_b, show_b;

    match_sm dut_a (
        .Clk(clk), .Reset_n(rst_n), .frame_tick(tick_a), .shot_hit(shot_a),
        .pickup_touch(touch_a), .keycode(key_a), .hearts(hearts_a), .alive(alive_a),
        .invuln(inv_a), .game_over(over_a), .draw(draw_a), .winner(win_a),
        .heart_showup(show_a)
    );

    match_sm #(.N_PLAYERS(4), .PICKUP_PERIOD(4)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .frame_tick(tick_b), .shot_hit(shot_b),
        .pickup_touch(touch_b), .keycode(key_b), .hearts(hearts_b), .alive(alive_b),
        .invuln(inv_b), .game_over(over_b), .draw(draw_b), .winner(win_b),
        .heart_showup(show_b)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t exp_q[$];
    vec_t tab_a[6];
    vec_t tab_b[8];
    bit   seen_show_a = 1'b0;

    always @(negedge clk) if (show_a === 1'b1) seen_show_a = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_alive(input logic [11:0] h);
        logic [3:0] r;
        for (int p = 0; p < 4; p++) r[p] = (h[3*p +: 3] != 3'd0);
        return r;
    endfunction

    function automatic vec_t mk(input int dut, input int pre, input logic [3:0] hit,
                                input logic [31:0] key, input logic [11:0] hearts,
                                input logic [3:0] inv, input logic over, input logic drw,
                                input logic [1:0] win);
        vec_t v;
        v.dut = dut; v.pre = pre; v.hit = hit; v.touch = 4'b0; v.key = key;
        v.hearts = hearts; v.inv = inv; v.over = over; v.drw = drw; v.win = win;
        v.show = 1'b0; v.chk_show = 1'b0;
        return v;
    endfunction

    task automatic tick_once(input int dut, input logic [3:0] hit, input logic [3:0] touch,
                             input logic [31:0] key);
        @(negedge clk);
        if (dut == 0) begin
            shot_a = hit[1:0]; touch_a = touch[1:0]; key_a = key; tick_a = 1'b1;
        end else begin
            shot_b = hit; touch_b = touch; key_b = key; tick_b = 1'b1;
        end
        @(negedge clk);
        tick_a = 1'b0; shot_a = '0; touch_a = '0; key_a = '0;
        tick_b = 1'b0; shot_b = '0; touch_b = '0; key_b = '0;
    endtask

    task automatic compare(input string name, input vec_t e);
        logic [11:0] h;
        logic [3:0]  al, iv;
        logic        ov, dr, sh;
        logic [1:0]  wn;
        if (e.dut == 0) begin
            h = {6'b0, hearts_a}; al = {2'b0, alive_a}; iv = {2'b0, inv_a};
            ov = over_a; dr = draw_a; wn = win_a; sh = show_a;
        end else begin
            h = hearts_b; al = alive_b; iv = inv_b;
            ov = over_b; dr = draw_b; wn = win_b; sh = show_b;
        end
        check({name, ".hearts"}, h, e.hearts);
        check({name, ".alive"}, al, exp_alive(e.hearts));
        check({name, ".invuln"}, iv, e.inv);
        check({name, ".game_over"}, ov, e.over);
        check({name, ".draw"}, dr, e.drw);
        if (e.over) check({name, ".winner"}, wn, e.win);
        if (e.chk_show) check({name, ".heart_showup"}, sh, e.show);
    endtask

    task automatic apply(input string name, input vec_t v, input bit chk);
        vec_t e;
        repeat (v.pre) tick_once(v.dut, 4'b0, 4'b0, 32'b0);
        if (chk) exp_q.push_back(v);
        tick_once(v.dut, v.hit, v.touch, v.key);
        if (chk) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL %s: scoreboard empty", name);
            end else begin
                e = exp_q.pop_front();
                compare(name, e);
            end
        end
    endtask

    initial begin
        vec_t v;
        tab_a[0] = mk(0, 0,  4'b0010, 32'h0,         12'o0021, 4'b0011, 1'b0, 1'b0, 2'd0);
        tab_a[1] = mk(0, 30, 4'b0000, 32'h0000_1500, 12'o0021, 4'b0000, 1'b0, 1'b0, 2'd0);
        tab_a[2] = mk(0, 0,  4'b0010, 32'h0,         12'o0011, 4'b0010, 1'b0, 1'b0, 2'd0);
        tab_a[3] = mk(0, 30, 4'b0011, 32'h0,         12'o0000, 4'b0000, 1'b1, 1'b1, 2'd0);
        tab_a[4] = mk(0, 0,  4'b0011, 32'h0,         12'o0000, 4'b0000, 1'b1, 1'b1, 2'd0);
        tab_a[5] = mk(0, 0,  4'b0000, 32'h1500_0000, 12'o0033, 4'b0000, 1'b0, 1'b0, 2'd0);

        tab_b[0] = mk(1, 0,  4'b1110, 32'h0,         12'o2223, 4'b1110, 1'b0, 1'b0, 2'd0);
        tab_b[1] = mk(1, 30, 4'b1110, 32'h0,         12'o1113, 4'b1110, 1'b0, 1'b0, 2'd0);
        tab_b[2] = mk(1, 30, 4'b1110, 32'h0,         12'o0003, 4'b0000, 1'b1, 1'b0, 2'd0);
        tab_b[3] = mk(1, 0,  4'b0000, 32'h0015_0000, 12'o3333, 4'b0000, 1'b0, 1'b0, 2'd0);
        tab_b[4] = mk(1, 0,  4'b1011, 32'h0,         12'o2322, 4'b1011, 1'b0, 1'b0, 2'd0);
        tab_b[5] = mk(1, 30, 4'b1011, 32'h0,         12'o1311, 4'b1011, 1'b0, 1'b0, 2'd0);
        tab_b[6] = mk(1, 30, 4'b1011, 32'h0,         12'o0300, 4'b0000, 1'b1, 1'b0, 2'd2);
        tab_b[7] = mk(1, 0,  4'b0000, 32'h0000_0015, 12'o3333, 4'b0000, 1'b0, 1'b0, 2'd0);

        rst_n = 1'b0;
        tick_a = 1'b0; shot_a = '0; touch_a = '0; key_a = '0;
        tick_b = 1'b0; shot_b = '0; touch_b = '0; key_b = '0;
        #22 rst_n = 1'b1;
        @(negedge clk);
        check("rst.hearts_a", hearts_a, 6'o33);
        check("rst.alive_a", alive_a, 2'b11);
        check("rst.invuln_a", inv_a, 2'b00);
        check("rst.game_over_a", over_a, 1'b0);
        check("rst.draw_a", draw_a, 1'b0);
        check("rst.winner_a", win_a, 2'd0);
        check("rst.showup_a", show_a, 1'b0);
        check("rst.hearts_b", hearts_b, 12'o3333);
        check("rst.alive_b", alive_b, 4'b1111);

        // Hit on P0, then immunity holds for exactly INVULN_FRAMES ticks.
        apply("hit1", mk(0, 0, 4'b0001, 32'h0, 12'o0032, 4'b0001, 1'b0, 1'b0, 2'd0), 1'b1);
        for (int k = 1; k <= 30; k++)
            apply($sformatf("hold%0d", k),
                  mk(0, 0, 4'b0001, 32'h0, 12'o0032, (k < 30) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 2'd0), 1'b1);
        apply("hit31", mk(0, 0, 4'b0001, 32'h0, 12'o0031, 4'b0001, 1'b0, 1'b0, 2'd0), 1'b1);

        for (int i = 0; i < 6; i++) apply($sformatf("a%0d", i), tab_a[i], 1'b1);
        for (int i = 0; i < 8; i++) apply($sformatf("b%0d", i), tab_b[i], 1'b1);

`ifdef TANKWARS_HEART_PICKUP_EN
        for (int i = 1; i <= 4; i++) begin
            v = mk(1, 0, (i == 1) ? 4'b0001 : 4'b0000, 32'h0, 12'o3332, 4'b0001, 1'b0, 1'b0, 2'd0);
            v.show = (i == 4); v.chk_show = 1'b1;
            apply($sformatf("pick%0d", i), v, 1'b1);
        end
        v = mk(1, 0, 4'b0000, 32'h0, 12'o3333, 4'b0001, 1'b0, 1'b0, 2'd0);
        v.touch = 4'b0011; v.show = 1'b0; v.chk_show = 1'b1;
        apply("pick5", v, 1'b1);
`else
        v = mk(0, 0, 4'b0000, 32'h0, 12'o0033, 4'b0000, 1'b0, 1'b0, 2'd0);
        v.touch = 4'b0011;
        for (int i = 0; i < 1000; i++) apply("nopick", v, 1'b0);
        check("nopick.showup_seen", seen_show_a, 1'b0);
        check("nopick.hearts_a", hearts_a, 6'o33);
`endif

        // Hits without frame_tick are ignored.
        @(negedge clk);
        shot_a = 2'b11;
        repeat (5) @(negedge clk);
        check("notick.hearts_a", hearts_a, 6'o33);
        check("notick.invuln_a", inv_a, 2'b00);
        shot_a = 2'b00;

        // Asynchronous reset in the middle of an immunity window.
        apply("prerst", mk(0, 0, 4'b0001, 32'h0, 12'o0032, 4'b0001, 1'b0, 1'b0, 2'd0), 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst.hearts_a", hearts_a, 6'o33);
        check("arst.invuln_a", inv_a, 2'b00);
        check("arst.alive_a", alive_a, 2'b11);
        check("arst.hearts_b", hearts_b, 12'o3333);
        check("arst.invuln_b", inv_b, 4'b0000);
        check("arst.game_over_b", over_b, 1'b0);
        check("arst.winner_b", win_b, 2'd0);
        check("arst.showup_b", show_b, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
